// File: rtl/memory_cycle.sv
// Memory-access stage: byte/half/word data memory with load extension,
// store byte enables, misalignment detection and the MEM/WB register.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   RegWriteM..PCPlus4M execute-side control, address and data
//   StallW, FlushW      MEM/WB hold / bubble
//   RegWriteW..MisalignW registered writeback-side outputs
module memory_cycle #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RdM,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic        StallW,
    input  logic        FlushW,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ReadDataW,
    output logic        MisalignW
);

    typedef struct packed {
        logic        reg_write;
        logic        result_src;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] pc_plus4;
        logic [31:0] read_data;
        logic        misalign;
    } wb_t;

    logic [31:0]   mem_q [0:DEPTH-1];

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [31:0]   rword;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic          ld_ok;
    logic          st_ok;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   ldata;
    logic          misalign;
    wb_t           wb_d;
    wb_t           wb_q;

    // Upper address bits are dropped so out-of-range accesses wrap.
    always_comb begin
        idx    = ALU_ResultM[AW+1:2];
        off    = ALU_ResultM[1:0];
        rword  = mem_q[idx];
        byte_v = rword[{off, 3'b000} +: 8];
        half_v = off[1] ? rword[31:16] : rword[15:0];
        ld_ok  = 1'b0;
        st_ok  = 1'b0;
        be     = 4'b0000;
        wdata  = WriteDataM;
        ldata  = 32'h0;
        case (Funct3M)
            3'b000: begin
                ld_ok = 1'b1;
                st_ok = 1'b1;
                be    = 4'b0001 << off;
                wdata = {4{WriteDataM[7:0]}};
                ldata = {{24{byte_v[7]}}, byte_v};
            end
            3'b100: begin
                ld_ok = 1'b1;
                ldata = {24'h0, byte_v};
            end
            3'b001: begin
                ld_ok = ~off[0];
                st_ok = ~off[0];
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{WriteDataM[15:0]}};
                ldata = {{16{half_v[15]}}, half_v};
            end
            3'b101: begin
                ld_ok = ~off[0];
                ldata = {16'h0, half_v};
            end
            3'b010: begin
                ld_ok = (off == 2'b00);
                st_ok = (off == 2'b00);
                be    = 4'b1111;
                ldata = rword;
            end
            default: ;
        endcase
        // Illegal or misaligned accesses neither write nor return data.
        if (!(MemWriteM && st_ok)) be = 4'b0000;
        if (!(ResultSrcM && ld_ok)) ldata = 32'h0;
        misalign = (ResultSrcM && !ld_ok) || (MemWriteM && !st_ok);
    end

    // Memory contents survive reset; stores ignore StallW/FlushW.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_comb begin
        wb_d.reg_write  = RegWriteM;
        wb_d.result_src = ResultSrcM;
        wb_d.rd         = RdM;
        wb_d.alu_result = ALU_ResultM;
        wb_d.pc_plus4   = PCPlus4M;
        wb_d.read_data  = ldata;
        wb_d.misalign   = misalign;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else if (FlushW) begin
            wb_q <= '0;
        end else if (!StallW) begin
            wb_q <= wb_d;
        end
    end

    assign RegWriteW   = wb_q.reg_write;
    assign ResultSrcW  = wb_q.result_src;
    assign RdW         = wb_q.rd;
    assign ALU_ResultW = wb_q.alu_result;
    assign PCPlus4W    = wb_q.pc_plus4;
    assign ReadDataW   = wb_q.read_data;
    assign MisalignW   = wb_q.misalign;

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: directed scenarios plus a
// randomized run against a byte-level reference memory.
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
    logic        StallW, FlushW;
    logic        RegWriteW, ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALU_ResultW, PCPlus4W, ReadDataW;
    logic        MisalignW;

    int checks = 0;
    int errors = 0;

    memory_cycle #(.DEPTH(1024), .AW(10)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .StallW(StallW), .FlushW(FlushW),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .ALU_ResultW(ALU_ResultW), .PCPlus4W(PCPlus4W),
        .ReadDataW(ReadDataW), .MisalignW(MisalignW)
    );

    always #5 clk = ~clk;

    function automatic logic [103:0] wout();
        return {RegWriteW, ResultSrcW, RdW, ALU_ResultW,
                PCPlus4W, ReadDataW, MisalignW};
    endfunction

    task automatic drive(input logic rw, input logic mw, input logic rs,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] pc);
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
        Funct3M = f3; RdM = rd; ALU_ResultM = a;
        WriteDataM = wd; PCPlus4M = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 3'b111, 5'h1F, 32'h13579BDF, 32'h2468ACE0, 32'hFFFF0004);
        step();
        checks++;
        if (RegWriteW !== 1'b1 || MisalignW !== 1'b1 || RdW !== 5'h1F) begin
            errors++;
            $display("FAIL preload: rw=%b mis=%b rd=%h want 1 1 1f",
                     RegWriteW, MisalignW, RdW);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (wout() !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0", wout());
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (wout() !== '0) begin
                errors++;
                $display("FAIL reset_hold%0d: got %h want 0", i, wout());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_extension();
        logic [2:0]  f3 [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12};
        logic [31:0] ex [5] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080,
                                32'hFFFF80FF, 32'h000080FF};
        drive(0, 1, 0, 3'b010, 5'd0, 32'h10, 32'h80FF7F01, 32'h4);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, f3[i], 5'd1, ad[i], 32'h0, 32'h8);
            step();
            checks++;
            if (ReadDataW !== ex[i] || MisalignW !== 1'b0) begin
                errors++;
                $display("FAIL ext%0d: got %h mis=%b want %h mis=0",
                         i, ReadDataW, MisalignW, ex[i]);
            end
        end
    endtask

    task automatic test_narrow();
        drive(0, 1, 0, 3'b010, 5'd0, 32'h20, 32'h11223344, 32'h4);
        step();
        drive(0, 1, 0, 3'b000, 5'd0, 32'h21, 32'hFFFFFFAA, 32'h4);
        step();
        drive(0, 1, 0, 3'b001, 5'd0, 32'h22, 32'h1234BEEF, 32'h4);
        step();
        drive(1, 0, 1, 3'b010, 5'd2, 32'h20, 32'h0, 32'h4);
        step();
        checks++;
        if (ReadDataW !== 32'hBEEFAA44) begin
            errors++;
            $display("FAIL narrow: got %h want beefaa44", ReadDataW);
        end
    endtask

    task automatic test_misalign();
        drive(0, 1, 0, 3'b010, 5'd0, 32'h21, 32'hDEADBEEF, 32'h4);
        step();
        checks++;
        if (MisalignW !== 1'b1) begin
            errors++;
            $display("FAIL sw_mis: got %b want 1", MisalignW);
        end
        drive(0, 1, 0, 3'b100, 5'd0, 32'h20, 32'h0BADF00D, 32'h4);
        step();
        checks++;
        if (MisalignW !== 1'b1) begin
            errors++;
            $display("FAIL st_illegal: got %b want 1", MisalignW);
        end
        drive(1, 0, 1, 3'b010, 5'd3, 32'h20, 32'h0, 32'h4);
        step();
        checks++;
        if (ReadDataW !== 32'hBEEFAA44 || MisalignW !== 1'b0) begin
            errors++;
            $display("FAIL mis_nowrite: got %h mis=%b want beefaa44 0",
                     ReadDataW, MisalignW);
        end
        drive(1, 0, 1, 3'b001, 5'd3, 32'h23, 32'h0, 32'h4);
        step();
        checks++;
        if (ReadDataW !== 32'h0 || MisalignW !== 1'b1) begin
            errors++;
            $display("FAIL lh_mis: got %h mis=%b want 0 1", ReadDataW, MisalignW);
        end
        drive(1, 0, 1, 3'b011, 5'd3, 32'h20, 32'h0, 32'h4);
        step();
        checks++;
        if (ReadDataW !== 32'h0 || MisalignW !== 1'b1) begin
            errors++;
            $display("FAIL ld_illegal: got %h mis=%b want 0 1", ReadDataW, MisalignW);
        end
    endtask

    task automatic test_stall_flush();
        drive(1, 0, 1, 3'b010, 5'd9, 32'h20, 32'h0, 32'h44);
        step();
        checks++;
        if (ReadDataW !== 32'hBEEFAA44 || RdW !== 5'd9 || RegWriteW !== 1'b1) begin
            errors++;
            $display("FAIL pre_stall: got %h rd=%0d want beefaa44 9", ReadDataW, RdW);
        end
        StallW = 1'b1;
        drive(0, 0, 0, 3'b000, 5'd3, 32'h55, 32'h0, 32'h99);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ReadDataW !== 32'hBEEFAA44 || RdW !== 5'd9 ||
                ALU_ResultW !== 32'h20 || PCPlus4W !== 32'h44 ||
                ResultSrcW !== 1'b1) begin
                errors++;
                $display("FAIL stall%0d: got rd=%0d alu=%h pc=%h data=%h",
                         i, RdW, ALU_ResultW, PCPlus4W, ReadDataW);
            end
        end
        FlushW = 1'b1;
        drive(1, 0, 1, 3'b010, 5'd4, 32'h20, 32'h0, 32'h48);
        step();
        checks++;
        if (RegWriteW !== 1'b0 || RdW !== 5'd0 || wout() !== '0) begin
            errors++;
            $display("FAIL flush: got %h want 0", wout());
        end
        StallW = 1'b0;
        FlushW = 1'b0;
    endtask

    task automatic test_wrap_pass();
        drive(0, 1, 0, 3'b010, 5'd0, 32'h1000, 32'hCAFEF00D, 32'h4);
        step();
        drive(1, 0, 1, 3'b010, 5'd5, 32'h0, 32'h0, 32'h4);
        step();
        checks++;
        if (ReadDataW !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wrap: got %h want cafef00d", ReadDataW);
        end
        drive(1, 0, 0, 3'b010, 5'd6, 32'hDEADBEEF, 32'h0, 32'h80);
        step();
        checks++;
        if (ALU_ResultW !== 32'hDEADBEEF || ReadDataW !== 32'h0 ||
            MisalignW !== 1'b0 || RdW !== 5'd6 || PCPlus4W !== 32'h80) begin
            errors++;
            $display("FAIL pass: alu=%h data=%h mis=%b want deadbeef 0 0",
                     ALU_ResultW, ReadDataW, MisalignW);
        end
    endtask

    // Reference: a flat byte array of the whole memory.
    logic [7:0] mb [0:4095];

    task automatic test_random();
        logic [103:0] exp_q = '0;
        logic [103:0] nxt;
        int kind, size, a;
        logic [2:0] f3;
        logic [31:0] addr, wd, v;
        logic ld, st, ok, stl, fl;
        for (int i = 0; i < 364; i++) begin
            if (i < 64) begin
                kind = 1; f3 = 3'b010; addr = 32'h100 + 4 * i;
                stl = 1'b0; fl = 1'b0;
            end else begin
                kind = $urandom_range(0, 2);
                f3 = 3'($urandom_range(0, 7));
                addr = 32'h100 + $urandom_range(0, 255);
                if ($urandom_range(0, 3) == 0) addr[31:12] = 20'($urandom);
                stl = ($urandom_range(0, 4) == 0);
                fl = ($urandom_range(0, 9) == 0);
            end
            wd = $urandom;
            ld = (kind == 0);
            st = (kind == 1);
            a = int'(addr % 4096);
            size = 0;
            if (ld) begin
                if (f3 == 0 || f3 == 4) size = 1;
                if (f3 == 1 || f3 == 5) size = 2;
                if (f3 == 2) size = 4;
            end else if (st) begin
                if (f3 <= 2) size = 1 << f3;
            end
            ok = (size != 0) && (a % size == 0);
            v = 0;
            if (ld && ok) begin
                for (int k = 0; k < size; k++) v |= 32'(mb[a + k]) << (8 * k);
                if (!f3[2] && size == 1 && v[7]) v |= 32'hFFFFFF00;
                if (!f3[2] && size == 2 && v[15]) v |= 32'hFFFF0000;
            end
            if (st && ok) begin
                for (int k = 0; k < size; k++) mb[a + k] = wd[8*k +: 8];
            end
            StallW = stl;
            FlushW = fl;
            drive(1'($urandom), st, ld, f3, 5'($urandom), addr, wd, $urandom);
            nxt = {RegWriteM, ld, RdM, addr, PCPlus4M, v, (ld || st) && !ok};
            if (fl) exp_q = '0;
            else if (!stl) exp_q = nxt;
            step();
            checks++;
            if (wout() !== exp_q) begin
                errors++;
                $display("FAIL rand%0d: got %h want %h", i, wout(), exp_q);
            end
        end
        StallW = 1'b0;
        FlushW = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        StallW = 1'b0;
        FlushW = 1'b0;
        drive(0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_extension();
        test_narrow();
        test_misalign();
        test_stall_flush();
        test_wrap_pass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
